// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher between the imem port and decode.
// Pipelined sequential fetch with an in-order response queue.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   redirect_valid_i/_fence_i      restart fetch (fence: drain first)
//   redirect_addr_i                new fetch PC, bits [1:0] ignored
//   mem_valid_o/_fence_o/_addr_o   imem request, accepted same cycle
//   mem_ready_i/_rdata_i           in-order imem response
//   out_valid_o/_pc_o/_instr_o     queue head to decode
//   out_ready_i                    decode accepts head
//   busy_o                         requests still in flight
module fetch_prefetch_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic            redirect_fence_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            mem_valid_o,
    output logic            mem_fence_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ready_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_instr_o,
    input  logic            out_ready_i,
    output logic            busy_o
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int QW = $clog2(DEPTH);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FENCE
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [TW-1:0]   trd_q, trd_d, twr_q, twr_d;

    logic [XLEN-1:0] q_pc  [DEPTH];
    logic [31:0]     q_ins [DEPTH];
    logic [XLEN-1:0] tag_q [MAX_OUT];

    logic            issue, fence_iss;
    logic            resp, drop, push, pop, credit;
    logic [SW-1:0]   inflight;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        if (p == TW'(MAX_OUT - 1)) return '0;
        return p + TW'(1);
    endfunction

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp = mem_ready_i && (outst_q != '0);
    assign drop = resp && ((disc_q != '0) || redirect_valid_i);
    assign push = resp && !drop;
    assign pop  = out_valid_o && out_ready_i;

    // Stale in-flight words will be dropped, so they reserve no queue slot.
    assign inflight = SW'(cnt_q) + SW'(outst_q) - SW'(disc_q);
    assign credit   = (outst_q < OW'(MAX_OUT)) && (inflight < SW'(DEPTH));

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        fence_iss = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN:  issue = credit && !redirect_valid_i;
            S_FENCE: begin
                if (outst_q == '0 && credit && !redirect_valid_i) begin
                    issue     = 1'b1;
                    fence_iss = 1'b1;
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A pending fence survives a later plain redirect.
        if (redirect_valid_i) begin
            if (redirect_fence_i || state_q == S_FENCE) state_d = S_FENCE;
            else state_d = S_RUN;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q + OW'(issue) - OW'(resp);
        disc_d  = disc_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        rd_d    = rd_q + QW'(pop);
        wr_d    = wr_q + QW'(push);
        trd_d   = resp ? tag_next(trd_q) : trd_q;
        twr_d   = issue ? tag_next(twr_q) : twr_q;
        if (issue) pc_d = pc_q + XLEN'(4);
        if (resp && disc_q != '0) disc_d = disc_q - OW'(1);
        if (redirect_valid_i) begin
            pc_d   = redirect_addr_i & ~XLEN'(3);
            disc_d = outst_q - OW'(resp);
            cnt_d  = '0;
            rd_d   = '0;
            wr_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            trd_q   <= '0;
            twr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            trd_q   <= trd_d;
            twr_q   <= twr_d;
        end
    end

    // Storage needs no reset: validity is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (issue) tag_q[twr_q] <= pc_q;
        if (push) begin
            q_pc[wr_q]  <= tag_q[trd_q];
            q_ins[wr_q] <= mem_rdata_i;
        end
    end

    assign mem_valid_o = issue;
    assign mem_fence_o = fence_iss;
    assign mem_addr_o  = issue ? pc_q : '0;
    assign out_valid_o = (cnt_q != '0);
    assign out_pc_o    = out_valid_o ? q_pc[rd_q] : '0;
    assign out_instr_o = out_valid_o ? q_ins[rd_q] : '0;
    assign busy_o      = (outst_q != '0) || (disc_q != '0);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios plus random
// traffic checked against a transaction-level reference model.
module tb_fetch_prefetch_unit;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic        redirect_fence_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        mem_valid_o, mem_fence_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        out_valid_o;
    logic [31:0] out_pc_o, out_instr_o;
    logic        out_ready_i = 1'b0;
    logic        busy_o;

    fetch_prefetch_unit #(
        .XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .redirect_valid_i(redirect_valid_i),
        .redirect_fence_i(redirect_fence_i),
        .redirect_addr_i(redirect_addr_i),
        .mem_valid_o(mem_valid_o), .mem_fence_o(mem_fence_o),
        .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_pc_o(out_pc_o),
        .out_instr_o(out_instr_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } req_t;

    req_t        imq[$];
    logic [31:0] mfifo[$];
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          gen = 0;
    int          lat = 1;
    int          issues = 0;
    int          fences = 0;
    bit          idle = 1'b0;
    bit          fence_mode = 1'b0;
    bit          saw_wrap = 1'b0;
    logic [31:0] exp_req = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit redir, input bit fen,
                         input logic [31:0] ra, input bit ordy,
                         input bit spur);
        bit   resp;
        bit   expv;
        int   live;
        req_t e;
        resp = (imq.size() > 0 && imq[0].due <= cyc) ||
               (spur && imq.size() == 0);
        redirect_valid_i = redir;
        redirect_fence_i = fen;
        redirect_addr_i  = ra;
        out_ready_i      = ordy;
        mem_ready_i      = resp;
        mem_rdata_i      = (imq.size() > 0) ? word_of(imq[0].addr)
                                            : 32'hDEAD_BEEF;
        #1;
        live = 0;
        foreach (imq[i]) if (imq[i].gen == gen) live++;
        expv = !idle && !redir && imq.size() < MAX_OUT &&
               (mfifo.size() + live) < DEPTH &&
               !(fence_mode && imq.size() > 0);
        chk("mem_valid", 32'(mem_valid_o), 32'(expv));
        chk("busy", 32'(busy_o), 32'(imq.size() > 0));
        chk("out_valid", 32'(out_valid_o), 32'(mfifo.size() > 0));
        if (mem_valid_o) begin
            chk("mem_addr", mem_addr_o, exp_req);
            chk("mem_fence", 32'(mem_fence_o), 32'(fence_mode));
        end else begin
            chk("mem_fence_noreq", 32'(mem_fence_o), 32'h0);
        end
        if (mfifo.size() > 0) begin
            chk("out_pc", out_pc_o, mfifo[0]);
            chk("out_instr", out_instr_o, word_of(mfifo[0]));
            if (ordy) void'(mfifo.pop_front());
        end
        if (resp && imq.size() > 0) begin
            e = imq.pop_front();
            if (e.gen == gen && !redir) mfifo.push_back(e.addr);
        end
        if (redir) begin
            mfifo.delete();
            gen++;
            exp_req = ra & ~32'h3;
            fence_mode = fence_mode | fen;
        end
        if (mem_valid_o) begin
            if (mem_addr_o == 32'h0 && exp_req == 32'h0) saw_wrap = 1'b1;
            if (mem_fence_o) fences++;
            imq.push_back('{addr: exp_req, gen: gen, due: cyc + lat});
            exp_req = exp_req + 32'h4;
            fence_mode = 1'b0;
            issues++;
        end
        idle = 1'b0;
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1;
        chk("rst_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("rst_mem_fence", 32'(mem_fence_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_out_valid", 32'(out_valid_o), 32'h0);
        chk("rst_out_pc", out_pc_o, 32'h0);
        chk("rst_out_instr", out_instr_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        idle = 1'b1;

        // Streaming, latency 1, decode always ready
        lat = 1;
        repeat (30) cycle(0, 0, '0, 1, 0);

        // Decode stalled: exactly DEPTH issues then hold
        cycle(1, 0, 32'h40, 0, 0);
        issues = 0;
        repeat (20) cycle(0, 0, '0, 0, 0);
        chk("stall_issue_count", 32'(issues), 32'(DEPTH));
        repeat (20) cycle(0, 0, '0, 1, 0);

        // Redirect with two requests in flight at latency 3
        lat = 3;
        for (int i = 0; i < 20 && imq.size() != 2; i++)
            cycle(0, 0, '0, 1, 0);
        chk("redir_two_out", 32'(imq.size()), 32'h2);
        cycle(1, 0, 32'h100, 1, 0);
        for (int i = 0; i < 30 && !out_valid_o; i++)
            cycle(0, 0, '0, 0, 0);
        chk("redir_first_pc", out_pc_o, 32'h100);
        repeat (10) cycle(0, 0, '0, 1, 0);

        // Fence redirect with two in flight
        for (int i = 0; i < 20 && imq.size() != 2; i++)
            cycle(0, 0, '0, 1, 0);
        fences = 0;
        cycle(1, 1, 32'h200, 1, 0);
        repeat (20) cycle(0, 0, '0, 1, 0);
        chk("single_fence", 32'(fences), 32'h1);

        // Redirect coinciding with a response and a pop
        lat = 1;
        for (int i = 0; i < 20 && !(mfifo.size() > 0 && imq.size() > 0 &&
                                    imq[0].due <= cyc); i++)
            cycle(0, 0, '0, 1, 0);
        cycle(1, 0, 32'h300, 1, 0);
        chk("redir_resp_pop_ov", 32'(out_valid_o), 32'h0);
        repeat (10) cycle(0, 0, '0, 1, 0);

        // Address wrap past 0xFFFFFFFC
        saw_wrap = 1'b0;
        cycle(1, 0, 32'hFFFF_FFF6, 1, 0);
        repeat (10) cycle(0, 0, '0, 1, 0);
        chk("pc_wrap", 32'(saw_wrap), 32'h1);

        // Spurious response with nothing outstanding
        repeat (12) cycle(0, 0, '0, 0, 0);
        repeat (3) cycle(0, 0, '0, 0, 1);
        repeat (10) cycle(0, 0, '0, 1, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bit r;
            lat = int'($urandom_range(1, 4));
            r = ($urandom_range(0, 19) == 0);
            cycle(r, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0), 0);
        end

        // Asynchronous reset with two requests in flight
        lat = 3;
        for (int i = 0; i < 20 && imq.size() != 2; i++)
            cycle(0, 0, '0, 1, 0);
        chk("arst_two_out", 32'(imq.size()), 32'h2);
        mem_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(mem_valid_o), 32'h0);
        chk("arst_mem_addr", mem_addr_o, 32'h0);
        chk("arst_out_valid", 32'(out_valid_o), 32'h0);
        chk("arst_out_pc", out_pc_o, 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        imq.delete();
        mfifo.delete();
        gen++;
        exp_req = 32'h0;
        fence_mode = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle = 1'b1;
        lat = 1;
        repeat (20) cycle(0, 0, '0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
